// File: rtl/fuzz_stim_sig_engine_if.sv
// Stim/response bus between the fuzz engine and the bench side (two DUT copies).
// Ports: start/seed in; stim out; y_ref/y_dut in; busy/done/mismatch/vec_idx/
//   first_bad_idx/sig_ref/sig_dut out; cap_* out only when FUZZ_MISMATCH_CAPTURE_EN is defined.
interface fuzz_stim_sig_engine_if #(
  parameter int IN_W  = 57,
  parameter int OUT_W = 258,
  parameter int SIG_W = 32,
  parameter int CNT_W = 5
);
  logic              start;
  logic [31:0]       seed;
  logic [IN_W-1:0]   stim;
  logic [OUT_W-1:0]  y_ref;
  logic [OUT_W-1:0]  y_dut;
  logic              busy;
  logic              done;
  logic              mismatch;
  logic [CNT_W-1:0]  vec_idx;
  logic [CNT_W-1:0]  first_bad_idx;
  logic [SIG_W-1:0]  sig_ref;
  logic [SIG_W-1:0]  sig_dut;
`ifdef FUZZ_MISMATCH_CAPTURE_EN
  logic [IN_W-1:0]   cap_stim;
  logic [OUT_W-1:0]  cap_y_ref;
  logic [OUT_W-1:0]  cap_y_dut;
`endif

  // Engine side.
  modport master (
    input  start, seed, y_ref, y_dut,
    output stim, busy, done, mismatch, vec_idx, first_bad_idx, sig_ref, sig_dut
`ifdef FUZZ_MISMATCH_CAPTURE_EN
    , output cap_stim, cap_y_ref, cap_y_dut
`endif
  );

  // Bench / DUT-pair side.
  modport slave (
    output start, seed, y_ref, y_dut,
    input  stim, busy, done, mismatch, vec_idx, first_bad_idx, sig_ref, sig_dut
`ifdef FUZZ_MISMATCH_CAPTURE_EN
    , input cap_stim, cap_y_ref, cap_y_dut
`endif
  );
endinterface

// File: rtl/fuzz_stim_sig_engine.sv
// Differential fuzz engine: seeded LFSR stimulus into two DUT copies, MISR compaction
// of both responses, sticky first-divergence flag. Optional mismatch capture registers
// when FUZZ_MISMATCH_CAPTURE_EN is defined.
// Ports: clk, rst (sync, active-high); bus (master modport of fuzz_stim_sig_engine_if).
// A run is NUM_VEC vectors held HOLD_CYC cycles each; no backpressure, start is ignored mid-run.
module fuzz_stim_sig_engine #(
  parameter int IN_W     = 57,
  parameter int OUT_W    = 258,
  parameter int NUM_VEC  = 20,
  parameter int HOLD_CYC = 2,
  parameter int SIG_W    = 32,
  parameter int CNT_W    = $clog2(NUM_VEC + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  fuzz_stim_sig_engine_if.master  bus
);

  localparam int NW   = (IN_W + 31) / 32;           // 32-bit stim words
  localparam int NS   = (OUT_W + SIG_W - 1) / SIG_W; // MISR fold slices
  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [31:0]      LFSR_TAPS = 32'h80200003;
  localparam logic [31:0]      GOLDEN    = 32'h9E3779B9;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] DONE_IDX  = CNT_W'(NUM_VEC);
  localparam logic [HC_W-1:0]  LAST_HOLD = HC_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      lfsr;
  logic [HC_W-1:0]  hold_cnt;
  logic [CNT_W-1:0] vec_idx;
  logic [CNT_W-1:0] first_bad_idx;
  logic [IN_W-1:0]  stim;
  logic [SIG_W-1:0] sig_ref;
  logic [SIG_W-1:0] sig_dut;
  logic             mismatch;
`ifdef FUZZ_MISMATCH_CAPTURE_EN
  logic [IN_W-1:0]  cap_stim;
  logic [OUT_W-1:0] cap_y_ref;
  logic [OUT_W-1:0] cap_y_dut;
`endif

  logic accept;    // start honoured this cycle
  logic sample;    // last hold cycle of the current vector
  logic last_vec;  // sampling the final vector of the run
  logic diverge;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Word k is the LFSR state whitened by k*golden-ratio so words of one vector differ.
  function automatic logic [IN_W-1:0] expand(input logic [31:0] l);
    logic [NW*32-1:0] w;
    w = '0;
    for (int k = 0; k < NW; k++) begin
      w[k*32 +: 32] = l ^ (32'(k) * GOLDEN);
    end
    return w[IN_W-1:0];
  endfunction

  function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] y);
    logic [NS*SIG_W-1:0] pad;
    logic [SIG_W-1:0]    acc;
    pad = '0;
    pad[OUT_W-1:0] = y;
    acc = '0;
    for (int s = 0; s < NS; s++) begin
      acc = acc ^ pad[s*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr(input logic [SIG_W-1:0] sig,
                                            input logic [OUT_W-1:0] y);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ fold(y);
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    last_vec  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        sample   = (hold_cnt == LAST_HOLD);
        last_vec = sample && (vec_idx == LAST_IDX);
        if (last_vec) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign diverge = sample && (bus.y_ref != bus.y_dut);

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr          <= 32'd1;
      hold_cnt      <= '0;
      vec_idx       <= '0;
      first_bad_idx <= '0;
      stim          <= '0;
      sig_ref       <= '0;
      sig_dut       <= '0;
      mismatch      <= 1'b0;
`ifdef FUZZ_MISMATCH_CAPTURE_EN
      cap_stim      <= '0;
      cap_y_ref     <= '0;
      cap_y_dut     <= '0;
`endif
    end else if (accept) begin
      // A zero seed would lock the LFSR at zero.
      lfsr          <= (bus.seed == 32'd0) ? 32'd1 : bus.seed;
      hold_cnt      <= '0;
      vec_idx       <= '0;
      first_bad_idx <= '0;
      stim          <= '0;
      sig_ref       <= '0;
      sig_dut       <= '0;
      mismatch      <= 1'b0;
`ifdef FUZZ_MISMATCH_CAPTURE_EN
      cap_stim      <= '0;
      cap_y_ref     <= '0;
      cap_y_dut     <= '0;
`endif
    end else if (state == RUN) begin
      if (sample) begin
        sig_ref  <= misr(sig_ref, bus.y_ref);
        sig_dut  <= misr(sig_dut, bus.y_dut);
        hold_cnt <= '0;
        if (diverge && !mismatch) begin
          mismatch      <= 1'b1;
          first_bad_idx <= vec_idx;
`ifdef FUZZ_MISMATCH_CAPTURE_EN
          cap_stim      <= stim;
          cap_y_ref     <= bus.y_ref;
          cap_y_dut     <= bus.y_dut;
`endif
        end
        if (last_vec) begin
          vec_idx <= DONE_IDX;
          stim    <= '0;
        end else begin
          // Stim is built from the stepped value so the new vector appears with the new index.
          lfsr    <= lfsr_step(lfsr);
          stim    <= expand(lfsr_step(lfsr));
          vec_idx <= vec_idx + 1'b1;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign bus.stim          = stim;
  assign bus.busy          = (state == RUN);
  assign bus.done          = (state == DONE);
  assign bus.mismatch      = mismatch;
  assign bus.vec_idx       = vec_idx;
  assign bus.first_bad_idx = first_bad_idx;
  assign bus.sig_ref       = sig_ref;
  assign bus.sig_dut       = sig_dut;
`ifdef FUZZ_MISMATCH_CAPTURE_EN
  assign bus.cap_stim      = cap_stim;
  assign bus.cap_y_ref     = cap_y_ref;
  assign bus.cap_y_dut     = cap_y_dut;
`endif

endmodule

// File: tb/tb_fuzz_stim_sig_engine.sv
module tb_fuzz_stim_sig_engine;
  localparam int IN_W     = 57;
  localparam int OUT_W    = 258;
  localparam int NUM_VEC  = 4;
  localparam int HOLD_CYC = 2;
  localparam int SIG_W    = 32;
  localparam int CNT_W    = $clog2(NUM_VEC + 1);
  localparam int NCYC     = NUM_VEC * HOLD_CYC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fuzz_stim_sig_engine_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

  fuzz_stim_sig_engine #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NUM_VEC), .HOLD_CYC(HOLD_CYC),
    .SIG_W(SIG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- Stand-in DUT pair ----------------
  logic [31:0]      salt;
  logic [7:0]       inj_vecs;   // vectors on which the "netlist" is corrupted
  logic [OUT_W-1:0] inj_mask;

  function automatic logic [OUT_W-1:0] ymodel(input logic [IN_W-1:0] s, input logic [31:0] sl);
    logic [OUT_W-1:0] y;
    for (int j = 0; j < OUT_W; j++)
      y[j] = s[j % IN_W] ^ (s[(j*7 + 3) % IN_W] & sl[j % 32]) ^ sl[(j + 5) % 32];
    return y;
  endfunction

  always_comb begin
    logic [OUT_W-1:0] yr;
    yr = ymodel(bus.stim, salt);
    bus.y_ref = yr;
    bus.y_dut = inj_vecs[bus.vec_idx] ? (yr ^ inj_mask) : yr;
  end

  // ---------------- Checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- Reference model ----------------
  logic [IN_W-1:0]  m_stim [NUM_VEC];
  logic [SIG_W-1:0] m_sig_ref, m_sig_dut;
  logic             m_mm;
  int               m_fb;
  logic [IN_W-1:0]  m_cap_stim;
  logic [OUT_W-1:0] m_cap_yr, m_cap_yd;

  function automatic logic [SIG_W-1:0] misr_model(input logic [SIG_W-1:0] s, input logic [OUT_W-1:0] y);
    logic [SIG_W-1:0] f;
    f = '0;
    for (int b = 0; b < OUT_W; b++) f[b % SIG_W] = f[b % SIG_W] ^ y[b];
    return {s[SIG_W-2:0], s[SIG_W-1]} ^ f;
  endfunction

  task automatic build_model(input logic [31:0] sd, input logic [31:0] sl,
                             input logic [7:0] vecs, input logic [OUT_W-1:0] mask);
    logic [31:0]      l, w;
    logic [OUT_W-1:0] yr, yd;
    l = (sd == 32'd0) ? 32'd1 : sd;
    m_sig_ref = '0; m_sig_dut = '0; m_mm = 1'b0; m_fb = 0;
    m_cap_stim = '0; m_cap_yr = '0; m_cap_yd = '0;
    for (int v = 0; v < NUM_VEC; v++) begin
      if (v == 0) begin
        m_stim[v] = '0;
      end else begin
        l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
        for (int i = 0; i < IN_W; i++) begin
          w = l ^ (32'(i / 32) * 32'h9E3779B9);
          m_stim[v][i] = w[i % 32];
        end
      end
      yr = ymodel(m_stim[v], sl);
      yd = vecs[v] ? (yr ^ mask) : yr;
      m_sig_ref = misr_model(m_sig_ref, yr);
      m_sig_dut = misr_model(m_sig_dut, yd);
      if (yr != yd && !m_mm) begin
        m_mm = 1'b1; m_fb = v;
        m_cap_stim = m_stim[v]; m_cap_yr = yr; m_cap_yd = yd;
      end
    end
  endtask

  task automatic setup(input logic [31:0] sd, input logic [31:0] sl, input logic [7:0] vecs, input int bit_i);
    logic [OUT_W-1:0] mask;
    mask = '0;
    mask[bit_i] = 1'b1;
    salt = sl; inj_vecs = vecs; inj_mask = mask;
    build_model(sd, sl, vecs, mask);
  endtask

  task automatic check_end(input string name);
    chk({name, " done"},      bus.done,          1'b1);
    chk({name, " busy"},      bus.busy,          1'b0);
    chk({name, " vec_idx"},   bus.vec_idx,       NUM_VEC);
    chk({name, " stim0"},     bus.stim,          '0);
    chk({name, " mismatch"},  bus.mismatch,      m_mm);
    chk({name, " first_bad"}, bus.first_bad_idx, m_fb);
    chk({name, " sig_ref"},   bus.sig_ref,       m_sig_ref);
    chk({name, " sig_dut"},   bus.sig_dut,       m_sig_dut);
`ifdef FUZZ_MISMATCH_CAPTURE_EN
    chk({name, " cap_stim"},  bus.cap_stim,      m_cap_stim);
    chk({name, " cap_y_ref"}, bus.cap_y_ref,     m_cap_yr);
    chk({name, " cap_y_dut"}, bus.cap_y_dut,     m_cap_yd);
`endif
  endtask

  // Full run: pulse start, follow the stim stream cycle by cycle, then check final state.
  task automatic do_run(input string name, input logic [31:0] sd,
                        output logic [31:0] w1_lo, output logic [24:0] w1_hi);
    int busy_cnt;
    logic [OUT_W-1:0] bad_a, bad_e;
    bad_a = '0; bad_e = '0; busy_cnt = 0; w1_lo = '0; w1_hi = '0;
    @(negedge clk); bus.start = 1'b1; bus.seed = sd;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 0; c < 4*NCYC && bus.done !== 1'b1; c++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (c == HOLD_CYC) begin
        w1_lo = bus.stim[31:0];
        w1_hi = bus.stim[IN_W-1:32];
      end
      if (c < NCYC && bad_a == '0 && bad_e == '0 &&
          {bus.vec_idx, bus.stim} !== {CNT_W'(c / HOLD_CYC), m_stim[c / HOLD_CYC]}) begin
        bad_a = {bus.vec_idx, bus.stim};
        bad_e = {CNT_W'(c / HOLD_CYC), m_stim[c / HOLD_CYC]};
      end
      @(negedge clk);
    end
    chk({name, " idx/stim stream"}, bad_a, bad_e);
    chk({name, " busy cycles"}, busy_cnt, NCYC);
    check_end(name);
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [7:0]  vecs;
    int          bit_i;
    logic        mm;
    int          fb;
    logic [31:0] w1_lo;
    logic [24:0] w1_hi;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] lo;
    logic [24:0] hi;
    int          busy_cnt;
    logic [31:0] sd;

    bus.start = 1'b1; bus.seed = 32'h0;
    salt = '0; inj_vecs = '0; inj_mask = '0;

    tbl[0] = '{32'h00000000, 8'h00,   0, 1'b0, 0, 32'h80200003, 25'h01779BA};
    tbl[1] = '{32'h00000001, 8'h04, 257, 1'b1, 2, 32'h80200003, 25'h01779BA};
    tbl[2] = '{32'h00000002, 8'h0A,   5, 1'b1, 1, 32'h00000001, 25'h03779B8};
    tbl[3] = '{32'h00000003, 8'h01, 100, 1'b1, 0, 32'h80200002, 25'h01779BB};
    tbl[4] = '{32'h12345678, 8'h08,   0, 1'b1, 3, 32'h091A2B3C, 25'h12D5285};

    // Reset held with start high: nothing may start.
    repeat (2) @(negedge clk);
    chk("rst busy",     bus.busy,     1'b0);
    chk("rst done",     bus.done,     1'b0);
    chk("rst mismatch", bus.mismatch, 1'b0);
    chk("rst stim",     bus.stim,     '0);
    chk("rst vec_idx",  bus.vec_idx,  '0);
    chk("rst sig_ref",  bus.sig_ref,  '0);
    chk("rst sig_dut",  bus.sig_dut,  '0);
    rst = 1'b0; bus.start = 1'b0;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      setup(tbl[i].seed, 32'h5A5A0000 + 32'(i), tbl[i].vecs, tbl[i].bit_i);
      do_run($sformatf("tbl%0d", i), tbl[i].seed, lo, hi);
      chk($sformatf("tbl%0d vec1 lo", i),    lo,                tbl[i].w1_lo);
      chk($sformatf("tbl%0d vec1 hi", i),    hi,                tbl[i].w1_hi);
      chk($sformatf("tbl%0d tbl mm", i),     bus.mismatch,      tbl[i].mm);
      chk($sformatf("tbl%0d tbl fb", i),     bus.first_bad_idx, tbl[i].fb);
    end
`ifdef FUZZ_MISMATCH_CAPTURE_EN
    // Last table run flagged vector 3 at bit 0; re-run entry 1 for the bit-257 capture.
    setup(tbl[1].seed, 32'h5A5A0001, tbl[1].vecs, tbl[1].bit_i);
    do_run("cap257", tbl[1].seed, lo, hi);
    chk("cap257 bit differs", bus.cap_y_dut[257] ^ bus.cap_y_ref[257], 1'b1);
`endif

    // Reset mid-run, then identical rerun must match an uninterrupted run.
    sd = 32'h0000CAFE;
    setup(sd, 32'h13579BDF, 8'h02, 77);
    @(negedge clk); bus.start = 1'b1; bus.seed = sd;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 0; c < 20 && bus.vec_idx !== CNT_W'(1); c++) @(negedge clk);
    chk("midrst reached v1", bus.vec_idx, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst busy",     bus.busy,          1'b0);
    chk("midrst done",     bus.done,          1'b0);
    chk("midrst mismatch", bus.mismatch,      1'b0);
    chk("midrst vec_idx",  bus.vec_idx,       '0);
    chk("midrst stim",     bus.stim,          '0);
    chk("midrst sigs",     {bus.sig_ref, bus.sig_dut}, '0);
    chk("midrst fb",       bus.first_bad_idx, '0);
    do_run("rerun", sd, lo, hi);

    // start during RUN is ignored: busy length must stay NUM_VEC*HOLD_CYC.
    sd = 32'hDEADBEEF;
    setup(sd, 32'h0F0F1234, 8'h06, 200);
    @(negedge clk); bus.start = 1'b1; bus.seed = 32'h11111111;
    @(negedge clk); bus.start = 1'b0;
    // The seed of the ignored start differs; only the accepted seed may matter.
    busy_cnt = 0;
    bus.seed = sd;
    for (int c = 0; c < 4*NCYC && bus.done !== 1'b1; c++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      bus.start = (c == 2*HOLD_CYC);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("ignore busy cycles", busy_cnt, NCYC);
    setup(32'h11111111, 32'h0F0F1234, 8'h06, 200);
    check_end("ignore");

    // start in DONE restarts at once.
    @(negedge clk); bus.start = 1'b1; bus.seed = sd;
    @(negedge clk); bus.start = 1'b0;
    chk("restart done",    bus.done,    1'b0);
    chk("restart busy",    bus.busy,    1'b1);
    chk("restart vec_idx", bus.vec_idx, '0);
    chk("restart sigs",    {bus.sig_ref, bus.sig_dut}, '0);
    chk("restart mm",      bus.mismatch, 1'b0);
    for (int c = 0; c < 4*NCYC && bus.done !== 1'b1; c++) @(negedge clk);
    setup(sd, 32'h0F0F1234, 8'h06, 200);
    check_end("restart");

    // Randomized runs against the model.
    for (int r = 0; r < 8; r++) begin
      sd = $urandom;
      setup(sd, $urandom, 8'($urandom_range(0, 15)), $urandom_range(0, OUT_W - 1));
      do_run($sformatf("rand%0d", r), sd, lo, hi);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
